cbi980_fifo_bank: RTL and testbench
===================================

# cbi980_fifo_bank

Parametrised multi-channel sample buffer for the CBI980 audio serial interface: one RX and one TX FIFO per channel. A register port gives the CPU access to data, status and control. A streaming port on the other side feeds the bit serializer and accepts words from the deserializer. It replaces the fixed two-channel, 16-deep buffering with configurable channel count, word width and depth. It also adds real full/empty tracking, sticky overflow/underflow flags with write-1-to-clear, per-channel masking and soft flush.

## Interface
- CHANNELS, 2, number of channels, 1..8
- WIDTH, 32, sample word width, 8..32
- DEPTH_LOG2, 4, log2 of FIFO depth; DEPTH = 2**DEPTH_LOG2, 2..64 entries
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- wr_addr  in  5  register write address
- wr_data  in  32  register write data
- wr_en  in  1  write strobe, one access per cycle
- wr_err  out  1  combinational; high in a wr_en cycle when the write is rejected
- rd_addr  in  5  register read address
- rd_en  in  1  read strobe; pops the RX FIFO for data addresses
- rd_data  out  32  registered read data
- rd_valid  out  1  high the cycle after rd_en
- tx_req  in  CHANNELS  per-channel pop request from the serializer
- tx_data  out  CHANNELS*WIDTH  popped words; channel c occupies [c*WIDTH +: WIDTH]
- tx_valid  out  CHANNELS  per-channel valid, registered
- rx_strobe  in  CHANNELS  per-channel push from the deserializer
- rx_data  in  CHANNELS*WIDTH  pushed words, same packing as tx_data
- interrupt  out  1  level interrupt, combinational from registered state

## Operation
- **Register map**
  - 0x00 ID (RO): {16'hcb19, 4'h1, CHANNELS-1[3:0], DEPTH_LOG2[3:0], 4'h0}.
  - 0x01 SR (RO): channel c at bits [4c+3:4c] = {rxne, rxf, txnf, txe}.
  - 0x02 CR (RW): [23:16] chen mask, [13:8] flag-type IE, [3] rxen, [2] txen, [0] flush (write-only, reads 0).
  - 0x03 SSR (RW1C): channel c at bits [2c+1:2c] = {rx_ovf, tx_unf}; writing 1 clears.
  - 0x10+c TXD (WO): push wr_data[WIDTH-1:0] into TX FIFO c.
  - 0x18+c RXD (RO): pop RX FIFO c; the word is zero-extended to 32 bits.
- **Rejected writes**
  - Affected addresses: 0x00, 0x01, any RXD, channel indices ≥ CHANNELS, unmapped addresses, and TXD to a full FIFO or a disabled channel.
  - Effect: wr_err=1 and no state changes.
- **Reads of unmapped addresses or channels ≥ CHANNELS** return 0.
- **FIFO bookkeeping**
  - Each FIFO uses DEPTH_LOG2+1-bit head/tail pointers; pointers wrap modulo 2*DEPTH.
  - empty when head==tail; full when the pointers differ only in the MSB.
  - txe=empty, txnf=!full, rxne=!empty, rxf=full.
- **RX path**
  - rx_strobe[c] pushes only when rxen=1 and chen[c]=1; otherwise it is ignored and no flag is set.
  - A push into a full FIFO is dropped, the FIFO is unchanged and rx_ovf[c] is set.
  - Exception: a CPU pop of that FIFO in the same cycle frees space, so the push is accepted.
- **TX path**
  - tx_req[c] with txen=1, chen[c]=1 and FIFO not empty pops the FIFO.
  - The word appears on tx_data[c] with tx_valid[c]=1 on the next cycle.
  - tx_req[c] on an empty FIFO sets tx_unf[c], drives tx_data[c]=0 and tx_valid[c]=0 the next cycle.
  - tx_req[c] while disabled is ignored, with tx_valid[c]=0 and no flag.
  - A CPU push into a full TX FIFO in the same cycle as a tx_req pop is accepted.
- **CPU RX read**
  - A read of an empty RX FIFO returns 0 and leaves the pointers unmoved.
  - A disabled channel's RX FIFO can still be read.
- **Sticky flags**
  - The set condition has priority over a W1C clear in the same cycle.
- **Interrupt**
  - Type vector {rx_ovf, tx_unf, rxne, rxf, txnf, txe} for channel c is ANDed with IE[13:8] and with chen[c].
  - interrupt is the OR of the result over all channels.
- **Flush**
  - A CR write with bit0=1 resets all pointers and sticky flags at that clock edge.
  - The other CR fields take the written values.
  - A simultaneous rx_strobe or tx_req in the flush cycle is discarded.
- **Reset values**
  - rd_data=0, rd_valid=0, tx_data=0, tx_valid=0, interrupt=0.
  - CR=0, all FIFOs empty, sticky flags 0.
  - SR therefore reads txe=txnf=1 for every channel.
  - FIFO storage is not reset.

## Timing
- Register read
  - rd_en in cycle n captures the data at the FIFO tail in cycle n.
  - rd_data and rd_valid are presented in n+1.
  - The pop takes effect at the n edge, so SR read in n+1 reflects it.
- Register write
  - State updates at the edge of the wr_en cycle.
  - wr_err is valid in the same cycle.
- Streaming
  - tx_req to tx_valid latency is 1 cycle.
  - rx_strobe to rxne latency is 1 cycle; SR read in the following cycle shows it.
- Throughput
  - One push and one pop per FIFO per cycle.
  - Back-to-back accesses are supported with no bubbles.
- Asynchronous reset
  - Asserting rst mid-operation clears state immediately.
  - Deassertion is synchronous to clk externally.

## Test plan
- Reset, then read 0x00 with CHANNELS=2, DEPTH_LOG2=4 -> rd_data=32'hcb19_1140; SR=32'h0000_0033; interrupt=0.
- CR=0x00030004, push 16 words to TXD0, then a 17th -> the 17th gives wr_err=1; tx_req[0] ×17 -> 16 words returned in order with tx_valid, then tx_valid=0 and SSR bit0=1.
- CR=0x0003_0008, 17 rx_strobe[1] with values 1..17 -> rxf[1]=1 and SSR bit3=1; 16 RXD1 reads return 1..16; a 17th read returns 0.
- CR IE[13]=1 (rx_ovf), overflow ch0 -> interrupt=1; write SSR=0x2 -> interrupt=0 next cycle; clear coincident with a new overflow -> flag stays 1.
- Full RX FIFO with rx_strobe and RXD read in the same cycle -> push accepted, still full, no ovf; pointer wrap verified over 100 cycles of random push/pop against a reference model.
- Flush while both FIFOs are half full -> SR returns to reset value next cycle; assert rst mid-burst -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/cbi980_fifo_bank.sv
// Multi-channel RX/TX sample FIFO bank for the CBI980 audio serial interface.
// CPU register port on one side, per-channel streaming port on the other.
module cbi980_fifo_bank #(
  parameter int CHANNELS   = 2,
  parameter int WIDTH      = 32,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [4:0]                wr_addr,
  input  logic [31:0]               wr_data,
  input  logic                      wr_en,
  output logic                      wr_err,
  input  logic [4:0]                rd_addr,
  input  logic                      rd_en,
  output logic [31:0]               rd_data,
  output logic                      rd_valid,
  input  logic [CHANNELS-1:0]       tx_req,
  output logic [CHANNELS*WIDTH-1:0] tx_data,
  output logic [CHANNELS-1:0]       tx_valid,
  input  logic [CHANNELS-1:0]       rx_strobe,
  input  logic [CHANNELS*WIDTH-1:0] rx_data,
  output logic                      interrupt
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2 + 1;
  typedef logic [PW-1:0] ptr_t;

  logic [7:0] chen;
  logic [5:0] ie;
  logic       rxen, txen;
  logic [CHANNELS-1:0] rx_ovf, tx_unf;
  ptr_t tx_head [CHANNELS];
  ptr_t tx_tail [CHANNELS];
  ptr_t rx_head [CHANNELS];
  ptr_t rx_tail [CHANNELS];
  logic [WIDTH-1:0] tx_mem [CHANNELS][DEPTH];
  logic [WIDTH-1:0] rx_mem [CHANNELS][DEPTH];

  logic [CHANNELS-1:0] tx_empty, tx_full, rx_empty, rx_full;
  logic [CHANNELS-1:0] tx_pop, tx_push, tx_unf_set, rx_pop, rx_push, rx_ovf_set;
  logic cr_wr, ssr_wr, flush;
  logic [31:0] id_word, sr_word, ssr_word, rd_word;
  logic irq;
  logic unused_bits;

  assign id_word = {16'hcb19, 4'h1, 4'(CHANNELS - 1), 4'(DEPTH_LOG2), 4'h0};
  assign cr_wr   = wr_en && (wr_addr == 5'h02);
  assign ssr_wr  = wr_en && (wr_addr == 5'h03);
  assign flush   = cr_wr && wr_data[0];
  assign unused_bits = ^{wr_data[31:24], wr_data[15:14], wr_data[7:4], wr_data[1]};

  // Full means the pointers differ only in the wrap bit; a same-cycle pop frees a slot.
  always_comb begin
    tx_empty = '0; tx_full = '0; rx_empty = '0; rx_full = '0;
    tx_pop = '0; tx_push = '0; tx_unf_set = '0;
    rx_pop = '0; rx_push = '0; rx_ovf_set = '0;
    sr_word = '0; ssr_word = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      tx_empty[c]   = tx_head[c] == tx_tail[c];
      tx_full[c]    = (tx_head[c] ^ tx_tail[c]) == ptr_t'(DEPTH);
      rx_empty[c]   = rx_head[c] == rx_tail[c];
      rx_full[c]    = (rx_head[c] ^ rx_tail[c]) == ptr_t'(DEPTH);
      tx_pop[c]     = tx_req[c] && txen && chen[c] && !tx_empty[c] && !flush;
      tx_unf_set[c] = tx_req[c] && txen && chen[c] && tx_empty[c] && !flush;
      tx_push[c]    = wr_en && (wr_addr == 5'(16 + c)) && txen && chen[c]
                      && (!tx_full[c] || tx_pop[c]);
      rx_pop[c]     = rd_en && (rd_addr == 5'(24 + c)) && !rx_empty[c];
      rx_push[c]    = rx_strobe[c] && rxen && chen[c] && !flush
                      && (!rx_full[c] || rx_pop[c]);
      rx_ovf_set[c] = rx_strobe[c] && rxen && chen[c] && !flush
                      && rx_full[c] && !rx_pop[c];
      sr_word[4*c +: 4]  = {!rx_empty[c], rx_full[c], !tx_full[c], tx_empty[c]};
      ssr_word[2*c +: 2] = {rx_ovf[c], tx_unf[c]};
    end
  end

  assign wr_err = wr_en && !(cr_wr || ssr_wr || (|tx_push));

  always_comb begin
    rd_word = '0;
    case (rd_addr)
      5'h00: rd_word = id_word;
      5'h01: rd_word = sr_word;
      5'h02: rd_word = {8'h0, chen, 2'b0, ie, 4'b0, rxen, txen, 2'b0};
      5'h03: rd_word = ssr_word;
      default: begin
        for (int c = 0; c < CHANNELS; c++)
          if ((rd_addr == 5'(24 + c)) && !rx_empty[c])
            rd_word = 32'(rx_mem[c][rx_tail[c][DEPTH_LOG2-1:0]]);
      end
    endcase
  end

  always_comb begin
    irq = 1'b0;
    for (int c = 0; c < CHANNELS; c++)
      irq = irq | (chen[c] & (|({rx_ovf[c], tx_unf[c], !rx_empty[c], rx_full[c],
                                  !tx_full[c], tx_empty[c]} & ie)));
  end
  assign interrupt = irq;

  // Sample storage carries no reset; only pointers decide what is valid.
  always_ff @(posedge clk) begin
    for (int c = 0; c < CHANNELS; c++) begin
      if (tx_push[c]) tx_mem[c][tx_head[c][DEPTH_LOG2-1:0]] <= wr_data[WIDTH-1:0];
      if (rx_push[c]) rx_mem[c][rx_head[c][DEPTH_LOG2-1:0]] <= rx_data[c*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      chen     <= '0;
      ie       <= '0;
      rxen     <= 1'b0;
      txen     <= 1'b0;
      rx_ovf   <= '0;
      tx_unf   <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      tx_data  <= '0;
      tx_valid <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        tx_head[c] <= '0; tx_tail[c] <= '0;
        rx_head[c] <= '0; rx_tail[c] <= '0;
      end
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_data <= rd_word;
      if (cr_wr) begin
        chen <= wr_data[23:16];
        ie   <= wr_data[13:8];
        rxen <= wr_data[3];
        txen <= wr_data[2];
      end
      for (int c = 0; c < CHANNELS; c++) begin
        tx_valid[c] <= tx_pop[c];
        tx_data[c*WIDTH +: WIDTH] <= tx_pop[c] ? tx_mem[c][tx_tail[c][DEPTH_LOG2-1:0]] : '0;
        if (flush) begin
          tx_head[c] <= '0; tx_tail[c] <= '0;
          rx_head[c] <= '0; rx_tail[c] <= '0;
          rx_ovf[c]  <= 1'b0;
          tx_unf[c]  <= 1'b0;
        end else begin
          if (tx_push[c]) tx_head[c] <= tx_head[c] + 1'b1;
          if (tx_pop[c])  tx_tail[c] <= tx_tail[c] + 1'b1;
          if (rx_push[c]) rx_head[c] <= rx_head[c] + 1'b1;
          if (rx_pop[c])  rx_tail[c] <= rx_tail[c] + 1'b1;
          // A new event wins over a write-1-to-clear in the same cycle.
          rx_ovf[c] <= rx_ovf_set[c] | (rx_ovf[c] & ~(ssr_wr & wr_data[2*c+1]));
          tx_unf[c] <= tx_unf_set[c] | (tx_unf[c] & ~(ssr_wr & wr_data[2*c]));
        end
      end
    end
  end
endmodule

// File: tb/tb_cbi980_fifo_bank.sv
// Directed bench for cbi980_fifo_bank (CHANNELS=2, WIDTH=32, DEPTH_LOG2=4).
module tb_cbi980_fifo_bank;
  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  wr_addr, rd_addr;
  logic [31:0] wr_data, rd_data;
  logic        wr_en, wr_err, rd_en, rd_valid, interrupt;
  logic [1:0]  tx_req, tx_valid, rx_strobe;
  logic [63:0] tx_data, rx_data;

  int n_assert = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] e, v;
  logic        psh, pp, exp_ovf;

  cbi980_fifo_bank #(.CHANNELS(2), .WIDTH(32), .DEPTH_LOG2(4)) dut (
    .clk(clk), .rst(rst),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en), .wr_err(wr_err),
    .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
    .tx_req(tx_req), .tx_data(tx_data), .tx_valid(tx_valid),
    .rx_strobe(rx_strobe), .rx_data(rx_data), .interrupt(interrupt)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout, required end of test");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the next negedge after the write edge.
  task automatic do_write(input logic [4:0] a, input logic [31:0] d, input logic exp_err,
                          input string tag);
    wr_addr = a; wr_data = d; wr_en = 1'b1;
    #1 check(tag, {31'b0, wr_err}, {31'b0, exp_err});
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic do_read(input logic [4:0] a, input logic [31:0] exp, input string tag);
    rd_addr = a; rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    check(tag, rd_data, exp);
    check("rd_valid", {31'b0, rd_valid}, 32'd1);
  endtask

  initial begin
    rst = 1'b0; wr_addr = '0; wr_data = '0; wr_en = 1'b0; rd_addr = '0; rd_en = 1'b0;
    tx_req = '0; rx_strobe = '0; rx_data = '0; exp_ovf = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_rd_data", rd_data, 32'h0);
    check("rst_rd_valid", {31'b0, rd_valid}, 32'h0);
    check("rst_tx_data0", tx_data[31:0], 32'h0);
    check("rst_tx_data1", tx_data[63:32], 32'h0);
    check("rst_tx_valid", {30'b0, tx_valid}, 32'h0);
    check("rst_irq", {31'b0, interrupt}, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    do_read(5'h00, 32'hcb19_1140, "id");
    do_read(5'h01, 32'h0000_0033, "sr_reset");
    check("irq_reset", {31'b0, interrupt}, 32'h0);

    // Rejected writes
    do_write(5'h00, 32'h1, 1'b1, "err_id");
    do_write(5'h01, 32'h1, 1'b1, "err_sr");
    do_write(5'h18, 32'h1, 1'b1, "err_rxd");
    do_write(5'h05, 32'h1, 1'b1, "err_unmapped");
    do_write(5'h10, 32'h1, 1'b1, "err_txd_disabled");

    // TX path: fill, overfill, drain with underflow
    do_write(5'h02, 32'h0003_0004, 1'b0, "cr_tx");
    do_write(5'h12, 32'h1, 1'b1, "err_txd_ch2");
    for (int i = 0; i < 16; i++) do_write(5'h10, 32'ha000_0000 + i, 1'b0, "txd0_push");
    do_write(5'h10, 32'hdead_beef, 1'b1, "txd0_full");
    do_read(5'h01, 32'h0000_0030, "sr_tx_full");
    tx_req = 2'b01;
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      check("tx_valid", {30'b0, tx_valid}, (i < 16) ? 32'h1 : 32'h0);
      check("tx_data", tx_data[31:0], (i < 16) ? 32'ha000_0000 + i : 32'h0);
    end
    tx_req = 2'b00;
    do_read(5'h03, 32'h0000_0001, "ssr_unf");
    do_write(5'h03, 32'h1, 1'b0, "ssr_clr");
    do_read(5'h03, 32'h0, "ssr_cleared");

    // RX path: overflow channel 1, then drain
    do_write(5'h02, 32'h0003_0008, 1'b0, "cr_rx");
    for (int i = 1; i <= 17; i++) begin
      rx_data[63:32] = i; rx_strobe = 2'b10;
      @(negedge clk);
    end
    rx_strobe = 2'b00;
    do_read(5'h01, 32'h0000_00f3, "sr_rx_full");
    do_read(5'h03, 32'h0000_0008, "ssr_ovf1");
    for (int i = 1; i <= 16; i++) do_read(5'h19, i, "rxd1");
    do_read(5'h19, 32'h0, "rxd1_empty");

    // Interrupt on rx_ovf, W1C and set-over-clear priority
    do_write(5'h03, 32'hf, 1'b0, "ssr_clr_all");
    do_write(5'h02, 32'h0003_2008, 1'b0, "cr_irq");
    check("irq_idle", {31'b0, interrupt}, 32'h0);
    for (int i = 0; i < 17; i++) begin
      rx_data[31:0] = 100 + i; rx_strobe = 2'b01;
      @(negedge clk);
    end
    rx_strobe = 2'b00;
    check("irq_ovf", {31'b0, interrupt}, 32'h1);
    do_write(5'h03, 32'h2, 1'b0, "ssr_w1c");
    check("irq_cleared", {31'b0, interrupt}, 32'h0);
    rx_data[31:0] = 32'd200; rx_strobe = 2'b01;
    do_write(5'h03, 32'h2, 1'b0, "ssr_w1c_coinc");
    rx_strobe = 2'b00;
    check("irq_set_wins", {31'b0, interrupt}, 32'h1);
    do_read(5'h03, 32'h0000_0002, "ssr_set_wins");

    // Full RX FIFO: push and CPU pop in the same cycle
    do_write(5'h03, 32'h2, 1'b0, "ssr_clr2");
    rx_data[31:0] = 32'h55; rx_strobe = 2'b01;
    do_read(5'h18, 32'd100, "rxd0_coinc");
    rx_strobe = 2'b00;
    do_read(5'h01, 32'h0000_003f, "sr_still_full");
    do_read(5'h03, 32'h0, "ssr_no_ovf");

    // Random push/pop on channel 0 against a queue model
    for (int i = 101; i <= 115; i++) exp_q.push_back(i);
    exp_q.push_back(32'h55);
    for (int k = 0; k < 100; k++) begin
      psh = 1'($urandom_range(0, 1)); pp = 1'($urandom_range(0, 1)); v = $urandom;
      rx_strobe = {1'b0, psh}; rx_data[31:0] = v; rd_addr = 5'h18; rd_en = pp;
      e = 32'h0;
      if (pp && exp_q.size() > 0) e = exp_q.pop_front();
      if (psh) begin
        if (exp_q.size() < 16) exp_q.push_back(v);
        else exp_ovf = 1'b1;
      end
      @(negedge clk);
      if (pp) check("rand_rd", rd_data, e);
    end
    rx_strobe = 2'b00; rd_en = 1'b0;
    do_read(5'h01, {24'h0, 4'h3, exp_q.size() != 0, exp_q.size() == 16, 2'b11}, "sr_rand");
    do_read(5'h03, exp_ovf ? 32'h2 : 32'h0, "ssr_rand");

    // Flush with FIFOs half full
    do_write(5'h02, 32'h0003_000c, 1'b0, "cr_both");
    for (int i = 0; i < 8; i++) begin
      do_write(5'h10, 32'h10 + i, 1'b0, "txd0_half");
      do_write(5'h11, 32'h20 + i, 1'b0, "txd1_half");
      rx_data[63:32] = 32'h30 + i; rx_strobe = 2'b10;
      @(negedge clk);
      rx_strobe = 2'b00;
    end
    do_read(5'h01, 32'h0000_00a0 | ({24'h0, exp_q.size() != 0, exp_q.size() == 16, 2'b10}),
            "sr_half");
    do_write(5'h02, 32'h0003_000d, 1'b0, "cr_flush");
    do_read(5'h01, 32'h0000_0033, "sr_flushed");
    do_read(5'h03, 32'h0, "ssr_flushed");
    do_read(5'h02, 32'h0003_000c, "cr_readback");

    // Asynchronous reset mid-burst
    do_write(5'h02, 32'h0003_020c, 1'b0, "cr_txnf_ie");
    for (int i = 0; i < 2; i++) begin
      do_write(5'h10, 32'h40 + i, 1'b0, "txd0_burst");
      do_write(5'h11, 32'h50 + i, 1'b0, "txd1_burst");
    end
    tx_req = 2'b11; rd_addr = 5'h00; rd_en = 1'b1;
    @(negedge clk);
    check("pre_rst_tx_valid", {30'b0, tx_valid}, 32'h3);
    check("pre_rst_irq", {31'b0, interrupt}, 32'h1);
    check("pre_rst_rd_data", rd_data, 32'hcb19_1140);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("arst_tx_valid", {30'b0, tx_valid}, 32'h0);
    check("arst_tx_data0", tx_data[31:0], 32'h0);
    check("arst_tx_data1", tx_data[63:32], 32'h0);
    check("arst_rd_data", rd_data, 32'h0);
    check("arst_rd_valid", {31'b0, rd_valid}, 32'h0);
    check("arst_irq", {31'b0, interrupt}, 32'h0);
    tx_req = 2'b00; rd_en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    do_read(5'h01, 32'h0000_0033, "sr_after_rst");
    do_read(5'h02, 32'h0, "cr_after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
